// File: rtl/spmv_mem_arbiter.sv
// Round-robin read arbiter for the SpMV memory port: grants one requester per cycle,
// tags the request with a free 6-bit transaction id and routes responses back by tag owner.
module spmv_mem_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 40,
    parameter int DATA_W = 512
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_val,
    output logic [NREQ-1:0]        req_rdy,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic                   mem_req_val,
    input  logic                   mem_req_rdy,
    output logic [5:0]             mem_req_transid,
    output logic [ADDR_W-1:0]      mem_req_addr,
    input  logic                   mem_resp_val,
    input  logic [5:0]             mem_resp_transid,
    input  logic [DATA_W-1:0]      mem_resp_data,
    output logic [NREQ-1:0]        rsp_val,
    output logic [DATA_W-1:0]      rsp_data,
    output logic [6:0]             inflight,
    output logic                   tag_err
);

    localparam int NTAG  = 64;
    localparam int TAG_W = 6;
    localparam int OWN_W = (NREQ > 2) ? $clog2(NREQ) : 1;

    // Tag table: allocation bits plus the requester that owns each tag
    logic [NTAG-1:0]     tag_alloc_reg;
    logic [NTAG-1:0]     tag_alloc_next;
    logic [OWN_W-1:0]    tag_owner_reg [NTAG];

    // Output register feeding the memory request channel
    logic                out_val_reg;
    logic [TAG_W-1:0]    out_tag_reg;
    logic [ADDR_W-1:0]   out_addr_reg;

    logic [OWN_W-1:0]    last_grant_reg;
    logic [6:0]          inflight_reg;
    logic [6:0]          inflight_next;
    logic                tag_err_reg;

    logic                loadable;
    logic                any_free;
    logic                any_req;
    logic                grant;
    logic [TAG_W-1:0]    free_tag;
    logic [OWN_W-1:0]    winner;
    logic [ADDR_W-1:0]   winner_addr;
    logic [ADDR_W-1:0]   addr_arr [NREQ];
    logic                resp_alloc;
    logic                resp_hit;
    logic                resp_miss;
    logic [OWN_W-1:0]    resp_owner;

    genvar gi;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_addr
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    assign loadable = !out_val_reg || mem_req_rdy;

    // Lowest-numbered free tag; descending scan lets the lowest index overwrite last
    always_comb begin
        free_tag = '0;
        any_free = 1'b0;
        for (int t = NTAG - 1; t >= 0; t--) begin
            if (!tag_alloc_reg[t]) begin
                free_tag = TAG_W'(t);
                any_free = 1'b1;
            end
        end
    end

    // Round-robin search starting just after the last winner; smallest offset wins
    always_comb begin
        int idx;
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(last_grant_reg) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req_val[idx]) begin
                winner  = OWN_W'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign winner_addr = addr_arr[winner];
    assign grant       = rst_n && loadable && any_free && any_req;

    assign resp_alloc = tag_alloc_reg[mem_resp_transid];
    assign resp_owner = tag_owner_reg[mem_resp_transid];
    assign resp_hit   = rst_n && mem_resp_val && resp_alloc;
    assign resp_miss  = rst_n && mem_resp_val && !resp_alloc;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_port
            assign req_rdy[gi] = grant && (winner == OWN_W'(gi));
            assign rsp_val[gi] = resp_hit && (resp_owner == OWN_W'(gi));
        end
    endgenerate

    assign rsp_data = mem_resp_data;

    // A tag is never granted and freed in the same cycle: grants only take free tags
    generate
        for (gi = 0; gi < NTAG; gi++) begin : g_tag
            assign tag_alloc_next[gi] =
                (grant && (free_tag == TAG_W'(gi))) ? 1'b1 :
                (resp_hit && (mem_resp_transid == TAG_W'(gi))) ? 1'b0 :
                tag_alloc_reg[gi];
        end
    endgenerate

    always_comb begin
        inflight_next = inflight_reg;
        if (grant && !resp_hit) begin
            inflight_next = inflight_reg + 7'd1;
        end else if (!grant && resp_hit) begin
            inflight_next = inflight_reg - 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_alloc_reg  <= '0;
            out_val_reg    <= 1'b0;
            out_tag_reg    <= '0;
            out_addr_reg   <= '0;
            last_grant_reg <= OWN_W'(NREQ - 1);
            inflight_reg   <= '0;
            tag_err_reg    <= 1'b0;
        end else begin
            tag_alloc_reg <= tag_alloc_next;
            inflight_reg  <= inflight_next;
            if (loadable) begin
                out_val_reg <= grant;
                if (grant) begin
                    out_tag_reg  <= free_tag;
                    out_addr_reg <= winner_addr;
                end
            end
            if (grant) begin
                last_grant_reg <= winner;
            end
            if (resp_miss) begin
                tag_err_reg <= 1'b1;
            end
        end
    end

    // Owner entries are only meaningful while the matching allocation bit is set
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_owner_reg[free_tag] <= winner;
        end
    end

    assign mem_req_val     = out_val_reg;
    assign mem_req_transid = out_tag_reg;
    assign mem_req_addr    = out_addr_reg;
    assign inflight        = inflight_reg;
    assign tag_err         = tag_err_reg;

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Scoreboard bench for spmv_mem_arbiter: expected memory requests are queued as
// stimulus is driven and checked when the request channel fires.
module tb_spmv_mem_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 40;
    localparam int DATA_W = 512;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [5:0]        tag;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_val;
    logic [NREQ-1:0]        req_rdy;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic                   mem_req_val;
    logic                   mem_req_rdy;
    logic [5:0]             mem_req_transid;
    logic [ADDR_W-1:0]      mem_req_addr;
    logic                   mem_resp_val;
    logic [5:0]             mem_resp_transid;
    logic [DATA_W-1:0]      mem_resp_data;
    logic [NREQ-1:0]        rsp_val;
    logic [DATA_W-1:0]      rsp_data;
    logic [6:0]             inflight;
    logic                   tag_err;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    spmv_mem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_val          (req_val),
        .req_rdy          (req_rdy),
        .req_addr         (req_addr),
        .mem_req_val      (mem_req_val),
        .mem_req_rdy      (mem_req_rdy),
        .mem_req_transid  (mem_req_transid),
        .mem_req_addr     (mem_req_addr),
        .mem_resp_val     (mem_resp_val),
        .mem_resp_transid (mem_resp_transid),
        .mem_resp_data    (mem_resp_data),
        .rsp_val          (rsp_val),
        .rsp_data         (rsp_data),
        .inflight         (inflight),
        .tag_err          (tag_err)
    );

    always #5 clk = ~clk;

    // Request channel monitor: every accepted memory request must match the queue head
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_req_val === 1'b1 && mem_req_rdy === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mem_req_unexpected: got addr=%h tag=%0d, required no request",
                         mem_req_addr, mem_req_transid);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_req_addr !== mon_e.addr || mem_req_transid !== mon_e.tag) begin
                    errors++;
                    $display("FAIL mem_req: got addr=%h tag=%0d, required addr=%h tag=%0d",
                             mem_req_addr, mem_req_transid, mon_e.addr, mon_e.tag);
                end else begin
                    $display("mem_req addr=%h tag=%0d", mem_req_addr, mem_req_transid);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
        req_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [5:0] t);
        exp_t e;
        e.addr = a;
        e.tag  = t;
        exp_q.push_back(e);
    endtask

    task automatic do_reset;
        tick;
        rst_n        = 1'b0;
        req_val      = '0;
        mem_resp_val = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n            = 1'b0;
        req_val          = '1;
        mem_req_rdy      = 1'b1;
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'd3;
        for (int i = 0; i < NREQ; i++) set_addr(i, ADDR_W'(40'h800 + i));
        repeat (2) tick;
        sample;
        checks++;
        if (req_rdy !== 4'b0000) begin
            errors++; $display("FAIL reset_req_rdy: got %b, required 0000", req_rdy);
        end
        checks++;
        if (rsp_val !== 4'b0000) begin
            errors++; $display("FAIL reset_rsp_val: got %b, required 0000", rsp_val);
        end
        checks++;
        if (mem_req_val !== 1'b0 || mem_req_transid !== 6'd0 || mem_req_addr !== '0) begin
            errors++;
            $display("FAIL reset_mem_req: got val=%b tag=%0d addr=%h, required 0/0/0",
                     mem_req_val, mem_req_transid, mem_req_addr);
        end
        checks++;
        if (inflight !== 7'd0 || tag_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got inflight=%0d tag_err=%b, required 0/0", inflight, tag_err);
        end
        tick;
        rst_n        = 1'b1;
        req_val      = '0;
        mem_resp_val = 1'b0;
        sample;
        checks++;
        if (tag_err !== 1'b0) begin
            errors++; $display("FAIL reset_resp_ignored: got tag_err=%b, required 0", tag_err);
        end
        tick;
    endtask

    task automatic test_single;
        logic [DATA_W-1:0] pat;
        pat         = {16{32'hC0DE_0000}} ^ DATA_W'(17);
        req_val     = 4'b0001;
        set_addr(0, 40'h100);
        mem_req_rdy = 1'b1;
        push_exp(40'h100, 6'd0);
        sample;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++; $display("FAIL single_grant: got req_rdy=%b, required 0001", req_rdy);
        end
        tick;
        req_val = '0;
        sample;
        checks++;
        if (mem_req_val !== 1'b1 || mem_req_transid !== 6'd0 || mem_req_addr !== 40'h100
            || inflight !== 7'd1) begin
            errors++;
            $display("FAIL single_issue: got val=%b tag=%0d addr=%h inflight=%0d, required 1/0/100/1",
                     mem_req_val, mem_req_transid, mem_req_addr, inflight);
        end
        tick;
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'd0;
        mem_resp_data    = pat;
        sample;
        checks++;
        if (rsp_val !== 4'b0001 || rsp_data !== pat) begin
            errors++;
            $display("FAIL single_resp: got rsp_val=%b data_ok=%b, required 0001 and payload",
                     rsp_val, rsp_data === pat);
        end
        $display("rsp tag=0 rsp_val=%b", rsp_val);
        tick;
        mem_resp_val = 1'b0;
        sample;
        checks++;
        if (inflight !== 7'd0 || tag_err !== 1'b0) begin
            errors++;
            $display("FAIL single_free: got inflight=%0d tag_err=%b, required 0/0", inflight, tag_err);
        end
        tick;
    endtask

    task automatic test_round_robin;
        logic [NREQ-1:0] oh;
        do_reset;
        mem_req_rdy = 1'b1;
        for (int i = 0; i < NREQ; i++) set_addr(i, ADDR_W'(40'h1000 + i * 40'h40));
        req_val = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            push_exp(ADDR_W'(40'h1000 + (k % 4) * 40'h40), 6'(k));
            oh = 4'b0001 << (k % 4);
            sample;
            checks++;
            if (req_rdy !== oh) begin
                errors++; $display("FAIL rr_grant%0d: got req_rdy=%b, required %b", k, req_rdy, oh);
            end
            $display("grant k=%0d req_rdy=%b", k, req_rdy);
            tick;
        end
        req_val = '0;
        sample;
        checks++;
        if (inflight !== 7'd8) begin
            errors++; $display("FAIL rr_inflight: got %0d, required 8", inflight);
        end
        tick;
    endtask

    task automatic test_backpressure;
        do_reset;
        mem_req_rdy = 1'b0;
        req_val     = 4'b0001;
        set_addr(0, 40'h200);
        push_exp(40'h200, 6'd0);
        sample;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++; $display("FAIL bp_first_grant: got req_rdy=%b, required 0001", req_rdy);
        end
        for (int c = 0; c < 5; c++) begin
            tick;
            set_addr(0, 40'h240);
            sample;
            checks++;
            if (req_rdy !== 4'b0000 || mem_req_val !== 1'b1 || mem_req_addr !== 40'h200
                || mem_req_transid !== 6'd0) begin
                errors++;
                $display("FAIL bp_hold%0d: got rdy=%b val=%b addr=%h tag=%0d, required 0000/1/200/0",
                         c, req_rdy, mem_req_val, mem_req_addr, mem_req_transid);
            end
        end
        tick;
        mem_req_rdy = 1'b1;
        push_exp(40'h240, 6'd1);
        sample;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++; $display("FAIL bp_release_grant: got req_rdy=%b, required 0001", req_rdy);
        end
        tick;
        req_val = '0;
        sample;
        tick;
        sample;
        checks++;
        if (mem_req_val !== 1'b0) begin
            errors++; $display("FAIL bp_once: got mem_req_val=%b, required 0", mem_req_val);
        end
        tick;
    endtask

    task automatic test_full;
        logic [DATA_W-1:0] pat;
        pat         = {16{32'hBEEF_0000}} ^ DATA_W'(5);
        do_reset;
        mem_req_rdy = 1'b1;
        req_val     = 4'b0010;
        for (int k = 0; k < 64; k++) begin
            set_addr(1, ADDR_W'(40'h4000 + k * 40'h40));
            push_exp(ADDR_W'(40'h4000 + k * 40'h40), 6'(k));
            sample;
            checks++;
            if (req_rdy !== 4'b0010) begin
                errors++; $display("FAIL full_grant%0d: got req_rdy=%b, required 0010", k, req_rdy);
            end
            tick;
        end
        set_addr(1, 40'h9000);
        sample;
        checks++;
        if (req_rdy !== 4'b0000 || inflight !== 7'd64) begin
            errors++;
            $display("FAIL full_stall: got req_rdy=%b inflight=%0d, required 0000/64", req_rdy, inflight);
        end
        tick;
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'd5;
        mem_resp_data    = pat;
        sample;
        checks++;
        if (rsp_val !== 4'b0010 || rsp_data !== pat || req_rdy !== 4'b0000) begin
            errors++;
            $display("FAIL full_resp: got rsp_val=%b data_ok=%b req_rdy=%b, required 0010/1/0000",
                     rsp_val, rsp_data === pat, req_rdy);
        end
        $display("rsp tag=5 rsp_val=%b", rsp_val);
        tick;
        mem_resp_val = 1'b0;
        push_exp(40'h9000, 6'd5);
        sample;
        checks++;
        if (req_rdy !== 4'b0010 || inflight !== 7'd63) begin
            errors++;
            $display("FAIL full_regrant: got req_rdy=%b inflight=%0d, required 0010/63", req_rdy, inflight);
        end
        tick;
        req_val = '0;
        sample;
        checks++;
        if (inflight !== 7'd64) begin
            errors++; $display("FAIL full_refill: got inflight=%0d, required 64", inflight);
        end
        tick;
    endtask

    task automatic test_bad_tag;
        do_reset;
        mem_req_rdy = 1'b1;
        req_val     = 4'b0001;
        set_addr(0, 40'h500);
        push_exp(40'h500, 6'd0);
        sample;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++; $display("FAIL bad_setup_grant: got req_rdy=%b, required 0001", req_rdy);
        end
        tick;
        req_val = '0;
        sample;
        tick;
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'd9;
        sample;
        checks++;
        if (rsp_val !== 4'b0000) begin
            errors++; $display("FAIL bad_rsp_val: got %b, required 0000", rsp_val);
        end
        $display("rsp tag=9 rsp_val=%b", rsp_val);
        tick;
        mem_resp_val = 1'b0;
        sample;
        checks++;
        if (tag_err !== 1'b1 || inflight !== 7'd1) begin
            errors++;
            $display("FAIL bad_tag_err: got tag_err=%b inflight=%0d, required 1/1", tag_err, inflight);
        end
        repeat (3) tick;
        sample;
        checks++;
        if (tag_err !== 1'b1) begin
            errors++; $display("FAIL bad_sticky: got tag_err=%b, required 1", tag_err);
        end
        tick;
    endtask

    task automatic test_same_cycle;
        logic [DATA_W-1:0] pat;
        pat              = {16{32'h1234_0000}};
        req_val          = 4'b0100;
        set_addr(2, 40'h300);
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'd0;
        mem_resp_data    = pat;
        push_exp(40'h300, 6'd1);
        sample;
        checks++;
        if (rsp_val !== 4'b0001 || req_rdy !== 4'b0100) begin
            errors++;
            $display("FAIL same_cycle: got rsp_val=%b req_rdy=%b, required 0001/0100", rsp_val, req_rdy);
        end
        $display("rsp tag=0 rsp_val=%b grant req_rdy=%b", rsp_val, req_rdy);
        tick;
        req_val      = '0;
        mem_resp_val = 1'b0;
        sample;
        checks++;
        if (inflight !== 7'd1) begin
            errors++; $display("FAIL same_inflight: got %0d, required 1", inflight);
        end
        tick;
    endtask

    task automatic test_reset_midop;
        rst_n            = 1'b0;
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'd1;
        sample;
        checks++;
        if (rsp_val !== 4'b0000) begin
            errors++; $display("FAIL midrst_rsp: got rsp_val=%b, required 0000", rsp_val);
        end
        tick;
        sample;
        checks++;
        if (inflight !== 7'd0 || tag_err !== 1'b0 || mem_req_val !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got inflight=%0d tag_err=%b val=%b, required 0/0/0",
                     inflight, tag_err, mem_req_val);
        end
        tick;
        rst_n = 1'b1;
        sample;
        checks++;
        if (rsp_val !== 4'b0000) begin
            errors++; $display("FAIL midrst_abandon: got rsp_val=%b, required 0000", rsp_val);
        end
        tick;
        mem_resp_val = 1'b0;
        sample;
        checks++;
        if (tag_err !== 1'b1) begin
            errors++; $display("FAIL midrst_tag_err: got tag_err=%b, required 1", tag_err);
        end
        tick;
    endtask

    initial begin
        rst_n            = 1'b0;
        req_val          = '0;
        req_addr         = '0;
        mem_req_rdy      = 1'b0;
        mem_resp_val     = 1'b0;
        mem_resp_transid = '0;
        mem_resp_data    = '0;
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_full;
        test_bad_tag;
        test_same_cycle;
        test_reset_midop;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
